// File: rtl/avmm_mem_arb2.sv
// avmm_mem_arb2: two-requester Avalon-MM arbiter in front of one shared
// memory bank.
//
// Commands from s0/s1 are arbitrated round-robin in IDLE. The grant is
// combinational in the same cycle. A write burst locks the bank to its owner
// until the last beat is accepted. Read responses are steered back to the
// issuing requester using a small FIFO of {owner, remaining beats} entries,
// with zero added latency.
//
// Ports
//   clk, reset                : clock, synchronous active-low reset
//   sN_address .. sN_byteenable : requester N command (N = 0, 1)
//   sN_waitrequest            : requester N stall
//   sN_readdata, sN_readdatavalid : requester N read response
//   m_address .. m_byteenable : command to the shared bank
//   m_waitrequest, m_readdata, m_readdatavalid : bank stall / read response
//   stat_grant0/1             : saturating per-requester command counters,
//                               present only when AVMM_MEM_ARB2_STATS_EN is
//                               defined
module avmm_mem_arb2 #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int RSP_FIFO_DEPTH  = 16,
  parameter int DATA_N_BYTES    = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_WIDTH-1:0]      s0_address,
  input  logic                       s0_read,
  input  logic                       s0_write,
  input  logic [BURST_CNT_WIDTH-1:0] s0_burstcount,
  input  logic [DATA_WIDTH-1:0]      s0_writedata,
  input  logic [DATA_N_BYTES-1:0]    s0_byteenable,
  output logic                       s0_waitrequest,
  output logic [DATA_WIDTH-1:0]      s0_readdata,
  output logic                       s0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]      s1_address,
  input  logic                       s1_read,
  input  logic                       s1_write,
  input  logic [BURST_CNT_WIDTH-1:0] s1_burstcount,
  input  logic [DATA_WIDTH-1:0]      s1_writedata,
  input  logic [DATA_N_BYTES-1:0]    s1_byteenable,
  output logic                       s1_waitrequest,
  output logic [DATA_WIDTH-1:0]      s1_readdata,
  output logic                       s1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]      m_address,
  output logic                       m_read,
  output logic                       m_write,
  output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
  output logic [DATA_WIDTH-1:0]      m_writedata,
  output logic [DATA_N_BYTES-1:0]    m_byteenable,
  input  logic                       m_waitrequest,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  input  logic                       m_readdatavalid
`ifdef AVMM_MEM_ARB2_STATS_EN
  ,
  output logic [31:0]                stat_grant0,
  output logic [31:0]                stat_grant1
`endif
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE  = 1;
  localparam logic [CNT_W-1:0]           CNT_ONE = 1;
  localparam logic [CNT_W-1:0]           CNT_FULL = RSP_FIFO_DEPTH[CNT_W-1:0];

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t                     state, state_nxt;
  logic                       rr_last;     // last winner
  logic                       owner;       // write-burst owner
  logic [BURST_CNT_WIDTH-1:0] beats_left;

  // read-routing FIFO; stored counts are always >= 1
  logic [RSP_FIFO_DEPTH-1:0]                      fifo_own;
  logic [RSP_FIFO_DEPTH-1:0][BURST_CNT_WIDTH-1:0] fifo_cnt;
  logic [PTR_W-1:0]                               rd_ptr, wr_ptr;
  logic [CNT_W-1:0]                               fifo_used;
  logic fifo_full, fifo_empty;

  logic elig0, elig1, grant_vld, win;
  logic sel_read, sel_write;
  logic rd_acc, wr_acc, accept;
  logic [BURST_CNT_WIDTH-1:0] bc_eff;
  logic rsp_hit, head_own, pop;

  assign fifo_full  = (fifo_used == CNT_FULL);
  assign fifo_empty = (fifo_used == '0);

  // Arbitration: burst owner is locked in WR_BURST; otherwise round-robin,
  // with reads ineligible while no routing slot is free.
  always_comb begin
    elig0     = s0_write | (s0_read & ~fifo_full);
    elig1     = s1_write | (s1_read & ~fifo_full);
    grant_vld = 1'b0;
    win       = 1'b0;
    if (!reset) begin
      grant_vld = 1'b0;
    end else if (state == WR_BURST) begin
      grant_vld = 1'b1;
      win       = owner;
    end else if (elig0 && elig1) begin
      grant_vld = 1'b1;
      win       = ~rr_last;
    end else if (elig0) begin
      grant_vld = 1'b1;
    end else if (elig1) begin
      grant_vld = 1'b1;
      win       = 1'b1;
    end
  end

  assign sel_read     = win ? s1_read       : s0_read;
  assign sel_write    = win ? s1_write      : s0_write;
  assign m_address    = win ? s1_address    : s0_address;
  assign m_burstcount = win ? s1_burstcount : s0_burstcount;
  assign m_writedata  = win ? s1_writedata  : s0_writedata;
  assign m_byteenable = win ? s1_byteenable : s0_byteenable;

  assign m_read  = grant_vld & (state == IDLE) & sel_read & ~fifo_full;
  assign m_write = grant_vld & sel_write;

  assign s0_waitrequest = (grant_vld && !win) ? m_waitrequest : 1'b1;
  assign s1_waitrequest = (grant_vld &&  win) ? m_waitrequest : 1'b1;

  assign rd_acc = m_read  & ~m_waitrequest;
  assign wr_acc = m_write & ~m_waitrequest;
  assign accept = rd_acc | wr_acc;
  assign bc_eff = (m_burstcount == '0) ? BC_ONE : m_burstcount;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (wr_acc && bc_eff != BC_ONE)     state_nxt = WR_BURST;
      WR_BURST: if (wr_acc && beats_left == BC_ONE) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_last    <= 1'b1;
      owner      <= 1'b0;
      beats_left <= '0;
    end else begin
      if (accept) rr_last <= win;
      if (state == IDLE && wr_acc) begin
        owner      <= win;
        beats_left <= bc_eff - BC_ONE;
      end else if (state == WR_BURST && wr_acc) begin
        beats_left <= beats_left - BC_ONE;
      end
    end
  end

  // Response steering: every bank beat belongs to the head entry; its last
  // beat pops it. A push never targets the head slot because reads are
  // blocked while full.
  assign head_own = fifo_own[rd_ptr];
  assign rsp_hit  = reset & m_readdatavalid & ~fifo_empty;
  assign pop      = rsp_hit & (fifo_cnt[rd_ptr] == BC_ONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_used <= '0;
    end else begin
      if (rd_acc) begin
        fifo_own[wr_ptr] <= win;
        fifo_cnt[wr_ptr] <= bc_eff;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)          rd_ptr <= rd_ptr + 1'b1;
      else if (rsp_hit) fifo_cnt[rd_ptr] <= fifo_cnt[rd_ptr] - BC_ONE;
      if (rd_acc && !pop)      fifo_used <= fifo_used + CNT_ONE;
      else if (!rd_acc && pop) fifo_used <= fifo_used - CNT_ONE;
    end
  end

  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = rsp_hit & ~head_own;
  assign s1_readdatavalid = rsp_hit &  head_own;

`ifdef AVMM_MEM_ARB2_STATS_EN
  // Only the first beat of a command counts, i.e. accepts taken in IDLE.
  logic first_acc;
  assign first_acc = accept & (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
    end else begin
      if (first_acc && !win && stat_grant0 != '1) stat_grant0 <= stat_grant0 + 32'd1;
      if (first_acc &&  win && stat_grant1 != '1) stat_grant1 <= stat_grant1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_avmm_mem_arb2.sv
module tb_avmm_mem_arb2;
  localparam int AW = 16, DW = 32, BW = 7, DEPTH = 2, NB = DW / 8;

  logic clk, reset;
  logic [AW-1:0] s0_address, s1_address, m_address;
  logic          s0_read, s0_write, s1_read, s1_write, m_read, m_write;
  logic [BW-1:0] s0_burstcount, s1_burstcount, m_burstcount;
  logic [DW-1:0] s0_writedata, s1_writedata, m_writedata;
  logic [NB-1:0] s0_byteenable, s1_byteenable, m_byteenable;
  logic          s0_waitrequest, s1_waitrequest, m_waitrequest;
  logic [DW-1:0] s0_readdata, s1_readdata, m_readdata;
  logic          s0_readdatavalid, s1_readdatavalid, m_readdatavalid;
`ifdef AVMM_MEM_ARB2_STATS_EN
  logic [31:0]   stat_grant0, stat_grant1;
`endif

  int checks = 0;
  int failures = 0;

  avmm_mem_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
                  .RSP_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_burstcount(s0_burstcount), .s0_writedata(s0_writedata),
    .s0_byteenable(s0_byteenable), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_burstcount(s1_burstcount), .s1_writedata(s1_writedata),
    .s1_byteenable(s1_byteenable), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
`ifdef AVMM_MEM_ARB2_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_read = 0; s0_write = 0; s0_address = '0; s0_burstcount = 7'd1;
    s0_writedata = '0; s0_byteenable = '1;
    s1_read = 0; s1_write = 0; s1_address = '0; s1_burstcount = 7'd1;
    s1_writedata = '0; s1_byteenable = '1;
    m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
  endtask

  // bank read data: a pure function of address and beat
  function automatic logic [31:0] mem_data(input logic [15:0] a, input int beat);
    return {a, 8'(beat), 8'h5A};
  endfunction

  // random-phase requester model
  typedef struct {
    logic busy; logic wr; logic [15:0] addr; logic [6:0] bc; int left; logic [31:0] wd;
  } rq_t;
  rq_t rq[2];
  logic [31:0] exp_rd0[$], exp_rd1[$], exp_wr[$], bank_q[$];

  initial begin
    idle_inputs();
    // ---- reset state
    reset = 0;
    s0_read = 1; s1_write = 1; m_readdatavalid = 1;
    #1;
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_rdv", {s0_readdatavalid, s1_readdatavalid}, 0);
    chk("rst_wait", {s0_waitrequest, s1_waitrequest}, 2'b11);
    tick(); tick();
    reset = 1;
    idle_inputs();

    // ---- alternating reads, port 0 first
    s0_read = 1; s0_address = 16'h0100;
    s1_read = 1; s1_address = 16'h0200;
    for (int c = 0; c < 4; c++) begin
      m_readdatavalid = (c > 0);
      m_readdata = 32'h1000 + c;
      #1;
      chk("alt_grant", m_address, (c % 2 == 0) ? 16'h0100 : 16'h0200);
      chk("alt_m_read", m_read, 1);
      if (c > 0) begin
        chk("alt_rdv0", s0_readdatavalid, (c % 2 == 1));
        chk("alt_rdv1", s1_readdatavalid, (c % 2 == 0));
        chk("alt_rdata", (c % 2 == 1) ? s0_readdata : s1_readdata, 32'h1000 + c);
      end
      tick();
    end
    s0_read = 0; s1_read = 0;
    m_readdatavalid = 1; m_readdata = 32'h1004;
    #1;
    chk("alt_drain", {s0_readdatavalid, s1_readdatavalid}, 2'b01);
    tick();
    m_readdatavalid = 0;

    // ---- s0 write burst of 4 blocks s1 read
    s0_write = 1; s0_address = 16'h0300; s0_burstcount = 7'd4;
    s1_read = 1; s1_address = 16'h0400; s1_burstcount = 7'd1;
    for (int c = 0; c < 4; c++) begin
      s0_writedata = 32'hBEEF_0000 + c;
      #1;
      chk("wb_m_write", m_write, 1);
      chk("wb_m_read", m_read, 0);
      chk("wb_addr", m_address, 16'h0300);
      chk("wb_wdata", m_writedata, 32'hBEEF_0000 + c);
      chk("wb_wait", {s0_waitrequest, s1_waitrequest}, 2'b01);
      tick();
    end
    s0_write = 0;
    #1;
    chk("wb_s1_grant", {m_read, m_address, s1_waitrequest}, {1'b1, 16'h0400, 1'b0});
    tick();
    s1_read = 0;
    m_readdatavalid = 1; m_readdata = 32'h0000_0055;
    #1;
    chk("wb_s1_rsp", {s0_readdatavalid, s1_readdatavalid, s1_readdata}, {2'b01, 32'h55});
    tick();
    m_readdatavalid = 0;

    // ---- burstcount 0 acts as a single beat
    s0_write = 1; s0_address = 16'h0500; s0_burstcount = 7'd0;
    #1;
    chk("bc0_write", {m_write, m_burstcount}, {1'b1, 7'd0});
    tick();
    s0_write = 0;
    s1_write = 1; s1_address = 16'h0600; s1_burstcount = 7'd1;
    #1;
    chk("bc0_next", {m_write, m_address, s1_waitrequest}, {1'b1, 16'h0600, 1'b0});
    tick();
    s1_write = 0;

    // ---- s0 burst 2 then s1 burst 3: routing of 5 beats
    s0_read = 1; s0_address = 16'h0700; s0_burstcount = 7'd2;
    #1; chk("rt_s0_cmd", {m_read, s0_waitrequest}, 2'b10);
    tick(); s0_read = 0;
    s1_read = 1; s1_address = 16'h0800; s1_burstcount = 7'd3;
    #1; chk("rt_s1_cmd", {m_read, m_address}, {1'b1, 16'h0800});
    tick(); s1_read = 0;
    for (int b = 0; b < 5; b++) begin
      m_readdatavalid = 1; m_readdata = 32'hD0 + b;
      #1;
      chk("rt_rdv", {s0_readdatavalid, s1_readdatavalid}, (b < 2) ? 2'b10 : 2'b01);
      chk("rt_data", (b < 2) ? s0_readdata : s1_readdata, 32'hD0 + b);
      tick();
    end
    m_readdatavalid = 0;

    // ---- FIFO full stalls the third read
    s0_read = 1; s0_address = 16'h0900; s0_burstcount = 7'd2;
    #1; chk("ff_acc0", s0_waitrequest, 0);
    tick(); s0_read = 0;
    s1_read = 1; s1_address = 16'h0A00; s1_burstcount = 7'd1;
    #1; chk("ff_acc1", s1_waitrequest, 0);
    tick(); s1_read = 0;
    s0_read = 1; s0_address = 16'h0B00; s0_burstcount = 7'd1;
    #1; chk("ff_stall", {s0_waitrequest, m_read}, 2'b10);
    tick();
    for (int b = 0; b < 2; b++) begin
      m_readdatavalid = 1; m_readdata = 32'hE0 + b;
      #1;
      chk("ff_stall_rsp", {s0_waitrequest, s0_readdatavalid, s0_readdata}, {2'b11, 32'hE0 + b});
      tick();
    end
    m_readdatavalid = 0;
    #1; chk("ff_release", {s0_waitrequest, m_read, m_address}, {2'b01, 16'h0B00});
    tick(); s0_read = 0;
    m_readdatavalid = 1; m_readdata = 32'hE2;
    #1; chk("ff_drain1", {s0_readdatavalid, s1_readdatavalid}, 2'b01);
    tick();
    m_readdata = 32'hE3;
    #1; chk("ff_drain0", {s0_readdatavalid, s1_readdatavalid}, 2'b10);
    tick();
    m_readdatavalid = 0;

    // ---- reset during beat 2 of a 4-beat write
    s0_write = 1; s0_address = 16'h0C00; s0_burstcount = 7'd4;
    #1; chk("mr_beat1", {m_write, s0_waitrequest}, 2'b10);
    tick();
    reset = 0;
    #1; chk("mr_in_reset", {m_write, m_read, s0_waitrequest}, 3'b001);
    tick();
    reset = 1; s0_write = 0;
    s1_write = 1; s1_address = 16'h0D00; s1_burstcount = 7'd1;
    m_readdatavalid = 1; m_readdata = 32'hDEAD;
    #1;
    chk("mr_stray", {s0_readdatavalid, s1_readdatavalid}, 2'b00);
    chk("mr_s1_grant", {m_write, m_address, s1_waitrequest}, {1'b1, 16'h0D00, 1'b0});
    tick();
    idle_inputs();

    // ---- randomized traffic against a requester/bank scoreboard
    for (int n = 0; n < 2; n++) rq[n] = '{busy: 0, wr: 0, addr: '0, bc: '0, left: 0, wd: '0};
    for (int cyc = 0; cyc < 3500; cyc++) begin
      logic gen;
      gen = (cyc < 3000);
      if (!gen && !rq[0].busy && !rq[1].busy && bank_q.size() == 0 &&
          exp_rd0.size() == 0 && exp_rd1.size() == 0) break;
      for (int n = 0; n < 2; n++)
        if (!rq[n].busy && gen && $urandom_range(0, 2) == 0) begin
          rq[n].busy = 1;
          rq[n].wr   = 1'($urandom_range(0, 1));
          rq[n].bc   = 7'($urandom_range(0, 3));
          rq[n].left = (rq[n].bc == 0) ? 1 : int'(rq[n].bc);
          rq[n].addr = {1'(n), 15'($urandom)};
          rq[n].wd   = $urandom;
        end
      s0_read = rq[0].busy & ~rq[0].wr; s0_write = rq[0].busy & rq[0].wr;
      s0_address = rq[0].addr; s0_burstcount = rq[0].bc; s0_writedata = rq[0].wd;
      s1_read = rq[1].busy & ~rq[1].wr; s1_write = rq[1].busy & rq[1].wr;
      s1_address = rq[1].addr; s1_burstcount = rq[1].bc; s1_writedata = rq[1].wd;
      m_waitrequest = ($urandom_range(0, 3) == 0);
      if (bank_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        m_readdatavalid = 1; m_readdata = bank_q[0];
      end else begin
        m_readdatavalid = 0; m_readdata = $urandom;
      end
      #1;
      // requester-side acceptance
      if (s0_read && !s0_waitrequest) begin
        for (int i = 0; i < rq[0].left; i++) exp_rd0.push_back(mem_data(rq[0].addr, i));
        rq[0].busy = 0;
      end
      if (s1_read && !s1_waitrequest) begin
        for (int i = 0; i < rq[1].left; i++) exp_rd1.push_back(mem_data(rq[1].addr, i));
        rq[1].busy = 0;
      end
      for (int n = 0; n < 2; n++)
        if ((n == 0 ? (s0_write && !s0_waitrequest) : (s1_write && !s1_waitrequest))) begin
          exp_wr.push_back(rq[n].wd);
          rq[n].wd = $urandom;
          rq[n].left--;
          if (rq[n].left == 0) rq[n].busy = 0;
        end
      // bank side
      if (m_write && !m_waitrequest) begin
        if (exp_wr.size() == 0) chk("rnd_wr_extra", 1, 0);
        else chk("rnd_wr_data", m_writedata, exp_wr.pop_front());
      end
      if (m_readdatavalid) begin
        void'(bank_q.pop_front());
        chk("rnd_rdv_onehot", {s0_readdatavalid, s1_readdatavalid} == 2'b01 ||
                              {s0_readdatavalid, s1_readdatavalid} == 2'b10, 1);
        if (s0_readdatavalid) begin
          if (exp_rd0.size() == 0) chk("rnd_rd0_extra", 1, 0);
          else chk("rnd_rd0_data", s0_readdata, exp_rd0.pop_front());
        end
        if (s1_readdatavalid) begin
          if (exp_rd1.size() == 0) chk("rnd_rd1_extra", 1, 0);
          else chk("rnd_rd1_data", s1_readdata, exp_rd1.pop_front());
        end
      end else begin
        chk("rnd_rdv_idle", {s0_readdatavalid, s1_readdatavalid}, 2'b00);
      end
      if (m_read && !m_waitrequest) begin
        int nb;
        nb = (m_burstcount == 0) ? 1 : int'(m_burstcount);
        for (int i = 0; i < nb; i++) bank_q.push_back(mem_data(m_address, i));
      end
      tick();
    end
    chk("rnd_drained", {rq[0].busy, rq[1].busy, 32'(bank_q.size() + exp_rd0.size() +
        exp_rd1.size() + exp_wr.size())}, '0);
    idle_inputs();

`ifdef AVMM_MEM_ARB2_STATS_EN
    // ---- statistics counters: 10 s0 and 7 s1 commands after reset
    reset = 0; tick(); reset = 1;
    chk("st_reset", {stat_grant0, stat_grant1}, '0);
    for (int c = 0; c < 17; c++) begin
      s0_read = (c < 10); s1_read = (c >= 10);
      s0_address = 16'h1000; s1_address = 16'h9000;
      m_readdatavalid = (c > 0); m_readdata = 32'(c);
      #1;
      chk("st_acc", m_read & ~m_waitrequest, 1);
      tick();
    end
    idle_inputs();
    m_readdatavalid = 1;
    tick();
    m_readdatavalid = 0;
    #1;
    chk("st_grant0", stat_grant0, 32'd10);
    chk("st_grant1", stat_grant1, 32'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/avmm_mem_arb2.md
AVMM_MEM_ARB2 -- requirements
Module: avmm_mem_arb2

Interface
REQ-001 Parameter ADDR_WIDTH, default 27: word address width.
REQ-002 Parameter DATA_WIDTH, default 512: data width, a multiple of 8; DATA_N_BYTES = DATA_WIDTH/8.
REQ-003 Parameter BURST_CNT_WIDTH, default 7: burstcount width.
REQ-004 Parameter RSP_FIFO_DEPTH, default 16: read-routing FIFO entries, a power of 2, at least 2.
REQ-005 Port clk  in  1  clock; all logic on the rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset.
REQ-007 Ports sN_address/sN_read/sN_write/sN_burstcount/sN_writedata/sN_byteenable, N=0,1  in  ADDR_WIDTH/1/1/BURST_CNT_WIDTH/DATA_WIDTH/DATA_N_BYTES  requester N command.
REQ-008 Ports sN_waitrequest/sN_readdata/sN_readdatavalid, N=0,1  out  1/DATA_WIDTH/1  requester N response.
REQ-009 Ports m_address/m_read/m_write/m_burstcount/m_writedata/m_byteenable  out  widths as REQ-007  shared bank command.
REQ-010 Ports m_waitrequest/m_readdata/m_readdatavalid  in  1/DATA_WIDTH/1  shared bank response.

Function
REQ-011 States: IDLE, WR_BURST; owner register: 1 bit; round-robin pointer: 1 bit, meaning last winner.
REQ-012 In IDLE, a requester is eligible when it asserts read or write; eligible reads are masked while the FIFO is full.
REQ-013 One eligible requester wins; if both are eligible, the winner is the one that is not the last winner; grant is combinational in the same cycle.
REQ-014 m_* command outputs equal the winner's inputs.
REQ-015 Winner's sN_waitrequest equals m_waitrequest; a non-winner sees sN_waitrequest=1.
REQ-016 With no winner, m_read=0, m_write=0, and s0_waitrequest=s1_waitrequest=1.
REQ-017 A command is accepted when (m_read or m_write) and !m_waitrequest; on accept, the pointer updates to the winner.
REQ-018 Read accept: push {winner, burstcount} to the FIFO; no state change; the next cycle arbitrates again.
REQ-019 Write accept with burstcount>1: go to WR_BURST, latch owner, set beats_left=burstcount-1.
REQ-020 WR_BURST: only the owner is connected to m_*; the other requester's waitrequest=1; the owner's read is forced low on m_read.
REQ-021 In WR_BURST, each accepted beat decrements beats_left; the accept at beats_left=1 returns to IDLE.
REQ-022 burstcount=0 is treated as 1.
REQ-023 m_readdatavalid with a non-empty FIFO: route m_readdata to the head owner's sN_readdata with sN_readdatavalid=1, the other requester's readdatavalid=0, and decrement the head count.
REQ-024 The last beat of a head entry pops it in that cycle; a push and pop in the same cycle are both honoured.
REQ-025 m_readdatavalid with an empty FIFO is dropped.
REQ-026 sN_readdata is driven from m_readdata unconditionally; latency from m_readdatavalid to sN_readdatavalid is zero cycles.
REQ-027 Read responses keep command order per requester and globally.

Reset
REQ-028 While reset=0 at a clk edge: state=IDLE, pointer=1 (port 0 wins first tie), owner=0, beats_left=0, FIFO empty.
REQ-029 During reset, all sN_readdatavalid=0 and m_read=m_write=0.
REQ-030 Reset mid-burst abandons the burst; responses arriving after reset are dropped (REQ-025).

Configuration
REQ-031 Macro AVMM_MEM_ARB2_STATS_EN defined: add outputs stat_grant0, stat_grant1 (32 bit), counting accepted commands (first beats only) per requester.
REQ-032 With AVMM_MEM_ARB2_STATS_EN defined: the counters saturate at all-ones and reset to 0.
REQ-033 AVMM_MEM_ARB2_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.

Verification
REQ-034 Both requesters read burstcount=1 every cycle, m_waitrequest=0 -> grants alternate 0,1,0,1, port 0 first after reset.
REQ-035 s0 writes burstcount=4 while s1 reads -> 4 consecutive s0 beats on m_*, s1_waitrequest=1 throughout, s1 read granted on the 5th cycle.
REQ-036 s0 reads burst 2, then s1 reads burst 3; memory returns 5 beats -> s0 gets beats 1-2, s1 gets beats 3-5, no misrouting.
REQ-037 RSP_FIFO_DEPTH=2: 2 reads accepted with no responses -> third read stalls (waitrequest=1) until the first response completes its burst.
REQ-038 Assert reset=0 in the middle of beat 2 of a 4-beat write -> IDLE next cycle; a stray m_readdatavalid is dropped; the next s1 write is granted normally.
REQ-039 With STATS_EN defined, 10 s0 and 7 s1 commands -> stat_grant0=10, stat_grant1=7.
